// File: rtl/conv_window_sequencer.sv
// Sequencer that walks a 3x3 window over an IMG_W x IMG_H frame and hands each RGB result downstream.
// Optional feature: define CONV_SEQ_PERF_CNT_EN to add the frame_cycles performance counter output.
module conv_window_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 32,
  parameter int IMG_H      = 32,
  parameter int PIPE_LAT   = 4,
  localparam int RW        = 2*DATA_WIDTH+6,
  localparam int CW        = $clog2(IMG_W),
  localparam int HW        = $clog2(IMG_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          load_weight,
  output logic          col_valid,
  output logic [CW-1:0] col_addr,
  output logic [HW-1:0] row_addr,
  output logic          total_window_done,
  input  logic [RW-1:0] conv_in,
  output logic [RW-1:0] result_data,
  output logic          result_valid,
`ifdef CONV_SEQ_PERF_CNT_EN
  output logic [31:0]   frame_cycles,
`endif
  input  logic          result_ready
);

  localparam int CNT_W = $clog2(PIPE_LAT+3);
  localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(2);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(PIPE_LAT-1);
  localparam logic [CW-1:0]    C_LAST     = CW'(IMG_W-3);
  localparam logic [HW-1:0]    R_LAST     = HW'(IMG_H-3);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_W, S_FEED, S_DRAIN, S_OUT, S_CLR, S_DONE
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CW-1:0]    c, c_n;
  logic [HW-1:0]    row, row_n;
  logic             abort_q, abort_n;
  logic             capture;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      c           <= '0;
      row         <= '0;
      abort_q     <= 1'b0;
      result_data <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      c       <= c_n;
      row     <= row_n;
      abort_q <= abort_n;
      if (capture) result_data <= conv_in;
    end
  end

  // An abort reuses CLR for cleanup; abort_q tells CLR to fall back to IDLE instead of advancing.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    c_n     = c;
    row_n   = row;
    abort_n = abort_q;
    capture = 1'b0;
    if (state != S_IDLE && abort) begin
      state_n = S_CLR;
      abort_n = 1'b1;
      cnt_n   = '0;
    end else begin
      case (state)
        S_IDLE:   if (start) state_n = S_LOAD_W;
        S_LOAD_W: begin
          c_n     = '0;
          row_n   = '0;
          cnt_n   = '0;
          state_n = S_FEED;
        end
        S_FEED: begin
          if (cnt == FEED_LAST) begin
            cnt_n   = '0;
            state_n = S_DRAIN;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        S_DRAIN: begin
          if (cnt == DRAIN_LAST) begin
            cnt_n   = '0;
            capture = 1'b1;
            state_n = S_OUT;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        S_OUT:    if (result_ready) state_n = S_CLR;
        S_CLR: begin
          abort_n = 1'b0;
          if (abort_q) begin
            state_n = S_IDLE;
          end else if (c == C_LAST && row == R_LAST) begin
            c_n     = '0;
            row_n   = '0;
            state_n = S_DONE;
          end else begin
            state_n = S_FEED;
            if (c == C_LAST) begin
              c_n   = '0;
              row_n = row + 1'b1;
            end else begin
              c_n = c + 1'b1;
            end
          end
        end
        S_DONE:   state_n = S_IDLE;
        default:  state_n = S_IDLE;
      endcase
    end
  end

  assign busy              = (state != S_IDLE);
  assign done              = (state == S_DONE);
  assign load_weight       = (state == S_LOAD_W);
  assign col_valid         = (state == S_FEED);
  assign col_addr          = col_valid ? c + CW'(cnt) : '0;
  assign row_addr          = row;
  assign total_window_done = (state == S_CLR);
  assign result_valid      = (state == S_OUT);

`ifdef CONV_SEQ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                         frame_cycles <= '0;
    else if (state == S_IDLE && start) frame_cycles <= '0;
    else if (busy)                   frame_cycles <= frame_cycles + 32'd1;
  end
`endif

endmodule
